prewish_mask_blinker: RTL

Downstream consumer of the mentor's strobe/mask output. Latches an 8-bit blink mask on STB_I and shows it MSB-first on one LED, one bit per prescaler period. Repeats the pattern forever until a new mask arrives. Sits between the mentor state machine and the board LED pin.

---
 rtl/prewish_pkg.sv | 10 +
 rtl/prewish_prescaler.sv | 25 ++
 rtl/prewish_mask_blinker.sv | 74 +++++++
 3 files changed

// File: rtl/prewish_pkg.sv
// Constants shared by the mentor state machine and the mask blinker.
`timescale 1ns/1ps
package prewish_pkg;
  localparam int MASK_W = 8;
  localparam int IDX_W  = 3;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;
endpackage

// File: rtl/prewish_prescaler.sv
// Free-running bit-period prescaler; TICK_O marks the last clock of each period.
`timescale 1ns/1ps
module prewish_prescaler #(
  parameter int PRESCALE_BITS = 22
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic clear,
  input  logic enable,
  output logic TICK_O
);
  logic [PRESCALE_BITS-1:0] r_count;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign TICK_O = &r_count;
endmodule

// File: rtl/prewish_mask_blinker.sv
// Latches an 8-bit blink mask and replays it MSB-first on one LED, forever.
`timescale 1ns/1ps
module prewish_mask_blinker
  import prewish_pkg::*;
#(
  parameter int PRESCALE_BITS = 22
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STB_I,
  input  logic [MASK_W-1:0] DAT_I,
  output logic              ACK_O,
  output logic              LED_O,
  output logic              SYNC_O,
  output logic              BUSY_O
);
  state_t            r_state;
  logic [MASK_W-1:0] r_mask;
  logic [IDX_W-1:0]  r_idx;
  logic              r_led;
  logic              r_ack;
  logic              r_sync;

  logic              w_run;
  logic              w_tick;
  logic              w_clear;
  logic [IDX_W-1:0]  w_idx_nxt;

  assign w_run     = (r_state == ST_RUN);
  // A load restarts the bit period, so the prescaler is cleared alongside it.
  assign w_clear   = STB_I || !w_run;
  assign w_idx_nxt = r_idx - 1'b1;

  prewish_prescaler #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_prescaler (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .clear (w_clear),
    .enable(w_run),
    .TICK_O(w_tick)
  );

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_idx   <= '1;
      r_led   <= 1'b0;
      r_ack   <= 1'b0;
      r_sync  <= 1'b0;
    end else begin
      r_ack <= STB_I;
      if (STB_I) begin
        r_state <= ST_RUN;
        r_mask  <= DAT_I;
        r_idx   <= '1;
        r_led   <= DAT_I[MASK_W-1];
        r_sync  <= 1'b0;
      end else if (w_run && w_tick) begin
        r_idx  <= w_idx_nxt;
        r_led  <= r_mask[w_idx_nxt];
        r_sync <= (r_idx == '0);
      end else begin
        r_sync <= 1'b0;
      end
    end
  end

  assign ACK_O  = r_ack;
  assign LED_O  = r_led;
  assign SYNC_O = r_sync;
  assign BUSY_O = w_run;
endmodule
